// File: rtl/io_uart.sv
// 8N1 UART peripheral on the core's 8-bit IO port bus: four ports at BASE_ADDR,
// TX/RX FIFOs, programmable baud divisor and a registered level interrupt.
module io_uart #(
   parameter logic [7:0] BASE_ADDR  = 8'h10,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] DIV_RESET  = 8'd16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] io_addr_i,
   input  logic [7:0] io_data_i,
   input  logic       io_we_i,
   output logic [7:0] io_data_o,
   output logic       irq_o,
   output logic       uart_tx_o,
   input  logic       uart_rx_i
);
   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   LV_DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic         w_sel, w_wr_data, w_wr_ctrl, w_wr_div, w_clr;
   logic [7:0]   r_div;
   logic         r_rx_ie, r_tx_ie, r_ovr, r_ferr, r_irq;

   assign w_sel     = (io_addr_i[7:2] == BASE_ADDR[7:2]);
   assign w_wr_data = io_we_i & w_sel & (io_addr_i[1:0] == 2'd0);
   assign w_wr_ctrl = io_we_i & w_sel & (io_addr_i[1:0] == 2'd2);
   assign w_wr_div  = io_we_i & w_sel & (io_addr_i[1:0] == 2'd3);
   assign w_clr     = w_wr_ctrl & io_data_i[3];

   // TX FIFO
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp;
   logic [AW:0]   r_tx_cnt;
   logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_load, w_tx_idle;

   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == LV_DEPTH);
   assign w_tx_push  = w_wr_data & ~w_tx_full;

   always_ff @(posedge clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= io_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_load) r_tx_rp <= r_tx_rp + 1'b1;
         case ({w_tx_push, w_tx_load})
            2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // TX FSM
   state_t     r_tx_st, w_tx_st_nxt;
   logic [7:0] r_tx_clk, r_tx_div, r_tx_sh;
   logic [2:0] r_tx_bit;
   logic       r_tx_o, w_tx_tick;

   assign w_tx_tick = (r_tx_clk == r_tx_div - 8'd1);
   assign w_tx_idle = w_tx_empty & (r_tx_st == S_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_tx_st <= S_IDLE;
      else       r_tx_st <= w_tx_st_nxt;
   end

   always_comb begin
      w_tx_st_nxt = r_tx_st;
      w_tx_load   = 1'b0;
      case (r_tx_st)
         S_IDLE:  if (!w_tx_empty) begin
                     w_tx_load   = 1'b1;
                     w_tx_st_nxt = S_START;
                  end
         S_START: if (w_tx_tick) w_tx_st_nxt = S_DATA;
         S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_st_nxt = S_STOP;
         S_STOP:  if (w_tx_tick) begin
                     // Back-to-back frames reload straight from STOP.
                     w_tx_load   = ~w_tx_empty;
                     w_tx_st_nxt = w_tx_empty ? S_IDLE : S_START;
                  end
         default: w_tx_st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_o   <= 1'b1;
         r_tx_clk <= '0;
         r_tx_bit <= '0;
      end else if (w_tx_load) begin
         r_tx_sh  <= r_tx_mem[r_tx_rp];
         r_tx_div <= r_div;
         r_tx_clk <= '0;
         r_tx_o   <= 1'b0;
      end else if (r_tx_st != S_IDLE) begin
         r_tx_clk <= w_tx_tick ? 8'd0 : r_tx_clk + 8'd1;
         if (w_tx_tick) begin
            case (r_tx_st)
               S_START: begin
                  r_tx_bit <= '0;
                  r_tx_o   <= r_tx_sh[0];
               end
               S_DATA: begin
                  if (r_tx_bit == 3'd7) begin
                     r_tx_o <= 1'b1;
                  end else begin
                     r_tx_bit <= r_tx_bit + 3'd1;
                     r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                     r_tx_o   <= r_tx_sh[1];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // RX synchroniser, falling-edge detect and FSM
   logic       r_rx_s1, r_rx_s2, r_rx_s3, w_rx_fall;
   state_t     r_rx_st, w_rx_st_nxt;
   logic [7:0] r_rx_clk, r_rx_div, r_rx_sh;
   logic [2:0] r_rx_bit;
   logic       w_rx_half, w_rx_tick, w_rx_done, w_ferr_set;

   assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
   assign w_rx_half = (r_rx_clk == (r_rx_div >> 1) - 8'd1);
   assign w_rx_tick = (r_rx_clk == r_rx_div - 8'd1);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_rx_st <= S_IDLE;
      else       r_rx_st <= w_rx_st_nxt;
   end

   always_comb begin
      w_rx_st_nxt = r_rx_st;
      w_rx_done   = 1'b0;
      w_ferr_set  = 1'b0;
      case (r_rx_st)
         S_IDLE:  if (w_rx_fall) w_rx_st_nxt = S_START;
         S_START: if (w_rx_half) w_rx_st_nxt = r_rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_st_nxt = S_STOP;
         S_STOP:  if (w_rx_tick) begin
                     // A bad stop bit re-arms only after the line returns high,
                     // which the falling-edge detector enforces by itself.
                     w_rx_st_nxt = S_IDLE;
                     w_rx_done   = r_rx_s2;
                     w_ferr_set  = ~r_rx_s2;
                  end
         default: w_rx_st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rx_s1  <= 1'b1;
         r_rx_s2  <= 1'b1;
         r_rx_s3  <= 1'b1;
         r_rx_clk <= '0;
         r_rx_bit <= '0;
      end else begin
         r_rx_s1 <= uart_rx_i;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         case (r_rx_st)
            S_IDLE: if (w_rx_fall) begin
                       r_rx_div <= r_div;
                       r_rx_clk <= '0;
                    end
            S_START: begin
               r_rx_clk <= w_rx_half ? 8'd0 : r_rx_clk + 8'd1;
               if (w_rx_half) r_rx_bit <= '0;
            end
            S_DATA: begin
               r_rx_clk <= w_rx_tick ? 8'd0 : r_rx_clk + 8'd1;
               if (w_rx_tick) begin
                  r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                  r_rx_bit <= r_rx_bit + 3'd1;
               end
            end
            default: r_rx_clk <= w_rx_tick ? 8'd0 : r_rx_clk + 8'd1;
         endcase
      end
   end

   // RX FIFO: a same-cycle pop frees the slot for a push into a full FIFO
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp;
   logic [AW:0]   r_rx_cnt;
   logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_ovr_set;

   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == LV_DEPTH);
   assign w_rx_pop   = w_wr_ctrl & io_data_i[0] & ~w_rx_empty;
   assign w_rx_push  = w_rx_done & (~w_rx_full | w_rx_pop);
   assign w_ovr_set  = w_rx_done & w_rx_full & ~w_rx_pop;

   always_ff @(posedge clk_i) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
         r_div    <= DIV_RESET;
         r_rx_ie  <= 1'b0;
         r_tx_ie  <= 1'b0;
         r_ovr    <= 1'b0;
         r_ferr   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
            default: ;
         endcase
         if (w_wr_div) r_div <= (io_data_i < 8'd2) ? 8'd2 : io_data_i;
         if (w_wr_ctrl) begin
            r_rx_ie <= io_data_i[1];
            r_tx_ie <= io_data_i[2];
         end
         r_ovr  <= w_ovr_set  | (r_ovr  & ~w_clr);
         r_ferr <= w_ferr_set | (r_ferr & ~w_clr);
         r_irq  <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_idle);
      end
   end

   always_comb begin
      io_data_o = 8'h00;
      if (w_sel) begin
         case (io_addr_i[1:0])
            2'd0: io_data_o = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
            2'd1: io_data_o = {2'b00, r_ferr, r_ovr, w_tx_full, w_tx_idle,
                               w_rx_full, ~w_rx_empty};
            2'd2: io_data_o = {5'b0, r_tx_ie, r_rx_ie, 1'b0};
            default: io_data_o = r_div;
         endcase
      end
   end

   assign irq_o     = r_irq;
   assign uart_tx_o = r_tx_o;

endmodule

// File: tb/tb_io_uart.sv
// Scoreboard bench for io_uart: TX waveform, loopback, RX overrun/frame errors,
// false-start rejection, interrupts and address decode.
module tb_io_uart;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] io_addr_i, io_data_i, io_data_o;
   logic       io_we_i, irq_o, uart_tx_o, uart_rx_i;
   logic       loop, bench_rx;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_q [$];
   logic       tx_q [$];

   always #5 clk = ~clk;

   assign uart_rx_i = loop ? uart_tx_o : bench_rx;

   io_uart #(.BASE_ADDR(8'h10), .FIFO_DEPTH(4), .DIV_RESET(8'd16)) dut (
      .clk_i(clk), .rst_i(rst), .io_addr_i(io_addr_i), .io_data_i(io_data_i),
      .io_we_i(io_we_i), .io_data_o(io_data_o), .irq_o(irq_o),
      .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      io_addr_i = a;
      io_data_i = d;
      io_we_i   = 1'b1;
      @(negedge clk);
      io_we_i   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      io_addr_i = a;
      #1;
      d = io_data_o;
   endtask

   task automatic send_bits(input logic [7:0] b);
      @(negedge clk);
      bench_rx = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bench_rx = b[i];
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      send_bits(b);
      bench_rx = stop;
      repeat (4) @(negedge clk);
      bench_rx = 1'b1;
   endtask

   task automatic wait_tx_idle(input string tag, input int limit);
      logic [7:0] st;
      logic       ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         rd(8'h11, st);
         if (st[2]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk(tag, 8'(ok), 8'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v, st;
      logic       ok;
      logic [7:0] tx_byte;

      rst = 1'b1; io_addr_i = 8'h00; io_data_i = 8'h00; io_we_i = 1'b0;
      loop = 1'b0; bench_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      rd(8'h10, v); chk("rst_data", v, 8'h00);
      rd(8'h11, v); chk("rst_status", v, 8'h04);
      rd(8'h12, v); chk("rst_ctrl", v, 8'h00);
      rd(8'h13, v); chk("rst_div", v, 8'h10);
      chk("rst_tx", 8'(uart_tx_o), 8'd1);
      chk("rst_irq", 8'(irq_o), 8'd0);

      // Divisor write, including the clamp of 1 to 2
      wr(8'h13, 8'd1); rd(8'h13, v); chk("div_clamp", v, 8'd2);
      wr(8'h13, 8'd4); rd(8'h13, v); chk("div_4", v, 8'd4);

      // TX waveform for A5 at DIV=4
      tx_byte = 8'hA5;
      for (int i = 0; i < 4; i++) tx_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
         for (int i = 0; i < 4; i++) tx_q.push_back(tx_byte[b]);
      for (int i = 0; i < 4; i++) tx_q.push_back(1'b1);
      wr(8'h10, tx_byte);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (uart_tx_o == 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("tx_start_seen", 8'(ok), 8'd1);
      for (int k = 0; k < 40; k++) begin
         chk($sformatf("tx_bit%0d", k), 8'(uart_tx_o), 8'(tx_q.pop_front()));
         if (k == 37) begin
            rd(8'h11, st);
            chk("tx_busy_in_stop", 8'(st[2]), 8'd0);
         end
         @(negedge clk);
      end
      rd(8'h11, st); chk("tx_idle_after", 8'(st[2]), 8'd1);

      // Loopback of two back-to-back bytes
      loop = 1'b1;
      wr(8'h10, 8'h3C); rx_q.push_back(8'h3C);
      wr(8'h10, 8'h81); rx_q.push_back(8'h81);
      wait_tx_idle("lb_tx_done", 200);
      repeat (6) @(negedge clk);
      loop = 1'b0;
      rd(8'h11, st); chk("lb_nonempty", 8'(st[0]), 8'd1);
      rd(8'h10, v);  chk("lb_byte0", v, rx_q.pop_front());
      wr(8'h12, 8'h01);
      rd(8'h10, v);  chk("lb_byte1", v, rx_q.pop_front());
      wr(8'h12, 8'h01);
      rd(8'h11, st); chk("lb_empty", 8'(st[0]), 8'd0);

      // Fill RX FIFO, then overrun while TX is kept busy
      for (int i = 0; i < 4; i++) begin
         v = 8'(8'h40 + i * 8'h13);
         send_rx(v, 1'b1);
         rx_q.push_back(v);
      end
      wr(8'h10, 8'h11); wr(8'h10, 8'h22); wr(8'h10, 8'h33); wr(8'h10, 8'h44);
      send_rx(8'hEE, 1'b1);
      repeat (4) @(negedge clk);
      rd(8'h11, st); chk("ovr_status", st, 8'h13);
      wr(8'h12, 8'h08);
      rd(8'h11, st); chk("ovr_cleared", st, 8'h03);
      for (int i = 0; i < 4; i++) begin
         rd(8'h10, v); chk($sformatf("full_byte%0d", i), v, rx_q.pop_front());
         wr(8'h12, 8'h01);
      end
      rd(8'h11, st); chk("full_drained", 8'(st[0]), 8'd0);
      wr(8'h12, 8'h01);
      rd(8'h11, st); chk("pop_empty_ignored", 8'(st[0]), 8'd0);
      wait_tx_idle("tx_drain", 400);

      // Frame error
      send_rx(8'h55, 1'b0);
      repeat (4) @(negedge clk);
      rd(8'h11, st); chk("ferr_status", st, 8'h24);
      wr(8'h12, 8'h08);
      rd(8'h11, st); chk("ferr_cleared", st, 8'h04);

      // One-clock glitch: false start
      @(negedge clk); bench_rx = 1'b0;
      @(negedge clk); bench_rx = 1'b1;
      repeat (20) @(negedge clk);
      rd(8'h11, st); chk("glitch_status", st, 8'h04);

      // RX interrupt timing
      wr(8'h12, 8'h02);
      rd(8'h12, v); chk("ctrl_rx_ie", v, 8'h02);
      send_bits(8'h7E); rx_q.push_back(8'h7E);
      bench_rx = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rd(8'h11, st);
         if (st[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("irq_rx_seen", 8'(ok), 8'd1);
      chk("irq_lag", 8'(irq_o), 8'd0);
      @(negedge clk);
      chk("irq_rise", 8'(irq_o), 8'd1);
      repeat (4) @(negedge clk);
      rd(8'h10, v); chk("irq_byte", v, rx_q.pop_front());
      wr(8'h12, 8'h03);
      chk("irq_hold", 8'(irq_o), 8'd1);
      @(negedge clk);
      chk("irq_fall", 8'(irq_o), 8'd0);

      // TX interrupt and address decode
      wr(8'h12, 8'h04);
      @(negedge clk);
      chk("irq_tx", 8'(irq_o), 8'd1);
      wr(8'h20, 8'h5A);
      repeat (3) @(negedge clk);
      rd(8'h11, st); chk("decode_no_effect", st, 8'h04);
      rd(8'h20, v);  chk("decode_rd20", v, 8'h00);
      rd(8'h23, v);  chk("decode_rd23", v, 8'h00);
      chk("decode_tx_line", 8'(uart_tx_o), 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
